mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequenced arbiter that shares the single 16-bit memory port of the multicycle CPU among three requesters: instruction fetch, CPU data access (load/store), and a DMA engine. It serialises requests, holds the memory command stable for a fixed memory latency, captures read data, and returns a one-cycle acknowledge to the winning requester. It sits between the CPU/DMA front ends and the memory model, replacing direct `readM`/`writeM`/`address` driving by the CPU.

## Interface
- `WORD`, 16, address and data width
- `LATENCY`, 2, memory access cycles per transaction; legal range 1..15
- `clk`  in  1  clock
- `reset_n`  in  1  reset, synchronous, active-low
- `req[2:0]`  in  3  request per requester: bit0 fetch, bit1 CPU data, bit2 DMA
- `we[2:0]`  in  3  per-requester write enable; `we[0]` ignored (fetch is read-only)
- `addr0`, `addr1`, `addr2`  in  WORD each  per-requester address
- `wdata1`, `wdata2`  in  WORD each  write data for CPU data and DMA
- `ack[2:0]`  out  3  one-hot, one-cycle completion pulse
- `gnt[2:0]`  out  3  one-hot owner of the port during BUSY and ACK; 0 in IDLE
- `rdata`  out  WORD  read data, valid in the cycle `ack` is high
- `mem_readM`  out  1  memory read strobe
- `mem_writeM`  out  1  memory write strobe
- `mem_addr`  out  WORD  memory address
- `mem_wdata`  out  WORD  memory write data
- `mem_rdata`  in  WORD  memory read data, valid in the last BUSY cycle

## Operation
- FSM states: IDLE, BUSY, ACK.
- IDLE: if `req` is nonzero at a clock edge, select the winner by round-robin, latch its address, write flag (fetch forced to read), and write data, set `gnt`, load the counter with LATENCY-1, and go to BUSY. If `req` is zero, stay in IDLE.
- Round-robin: search starts at (last_grant+1) mod 3. After reset, last_grant=2, so the search order is 0,1,2. last_grant updates when a winner is selected.
- BUSY:
  - `mem_addr` and `mem_wdata` are driven from the latched values.
  - Exactly one of `mem_readM`/`mem_writeM` is high for all LATENCY cycles.
  - The counter decrements each cycle.
  - At counter==0: capture `mem_rdata` into `rdata` (reads only; writes leave `rdata` unchanged) and go to ACK.
- ACK: `ack[winner]`=1 for exactly one cycle, strobes low, then go to IDLE. `gnt` clears on leaving ACK.
- Requester protocol:
  - Hold `req`, address, `we`, and data stable until ack.
  - Drop `req` at the edge ending the ack cycle, or keep it high to request again.
- Protocol violations:
  - Inputs are sampled only in IDLE. Changes during BUSY/ACK are ignored.
  - If `req` drops mid-transaction, the transaction still completes and is acked.
- Requests arriving during BUSY/ACK wait. They are arbitrated at the next IDLE edge.
- `mem_addr`/`mem_wdata` hold their last values in IDLE/ACK. Strobes are the only command qualifiers.

## Timing
- Reset values (at the reset edge): state IDLE, `ack`=0, `gnt`=0, `rdata`=0, `mem_readM`=0, `mem_writeM`=0, `mem_addr`=0, `mem_wdata`=0, counter 0, last_grant=2.
- Reset mid-transaction: everything returns to reset values at that edge. Strobes are low the next cycle and no ack is issued for the aborted transaction.
- Latency: `req` sampled at edge E0, strobes high in cycles E0+1..E0+LATENCY, ack in cycle E0+LATENCY+1. Total request-to-ack latency is LATENCY+1 cycles after the sampling edge.
- Throughput: one transaction per LATENCY+2 cycles (IDLE, BUSY×LATENCY, ACK). No back-to-back BUSY without an IDLE cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- The counter width is 4 bits, and LATENCY=1 gives a single BUSY cycle. Simultaneous requests resolve in the same IDLE cycle; losers see no ack and keep waiting.

## Test plan
- Single fetch, LATENCY=2: `req`=001, `addr0`=0x0010, memory returns 0xA5A5 → `mem_readM` high 2 cycles with `mem_addr`=0x0010, `ack`=001 3 cycles after the sampling edge, `rdata`=0xA5A5, `mem_writeM` never high.
- Fetch write ignored: `req`=001, `we`=001 → `mem_readM` asserts, `mem_writeM` stays 0.
- DMA write: `req`=100, `we`=100, `addr2`=0x0200, `wdata2`=0x1234 → `mem_writeM` 2 cycles, `mem_wdata`=0x1234, `ack`=100, `rdata` unchanged.
- Fairness: hold `req`=111 continuously from reset → grant/ack order is 0,1,2,0,1,2. Each requester is acked once per three transactions, with every transaction spaced LATENCY+2 cycles.
- Late arrival: `req`=010 in flight, `req[0]` rises during BUSY → the data transaction completes, then the fetch is granted at the next IDLE edge and the data requester is not re-granted first if it also re-requests (pointer moved past 1).
- Reset mid-BUSY: assert `reset_n`=0 in the first BUSY cycle → strobes, `gnt`, and `ack` are 0 the next cycle, no ack for the aborted request. After release with `req`=111, requester 0 is granted first.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sequencer sharing one memory port among fetch, CPU data and DMA.
module mem_port_arbiter #(
  parameter int WORD    = 16,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [2:0]      req,
  input  logic [2:0]      we,
  input  logic [WORD-1:0] addr0,
  input  logic [WORD-1:0] addr1,
  input  logic [WORD-1:0] addr2,
  input  logic [WORD-1:0] wdata1,
  input  logic [WORD-1:0] wdata2,
  output logic [2:0]      ack,
  output logic [2:0]      gnt,
  output logic [WORD-1:0] rdata,
  output logic            mem_readM,
  output logic            mem_writeM,
  output logic [WORD-1:0] mem_addr,
  output logic [WORD-1:0] mem_wdata,
  input  logic [WORD-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
  state_t          r_state, w_state;
  logic [3:0]      r_cnt, w_cnt;
  logic [1:0]      r_last, w_last;
  logic [2:0]      r_ack, w_ack, r_gnt, w_gnt;
  logic [WORD-1:0] r_rdata, w_rdata, r_addr, w_addr, r_wdata, w_wdata;
  logic            r_rd, w_rd, r_wr, w_wr;
  logic [1:0]      w_o0, w_o1, w_o2, w_win;
  logic            w_we;
  logic [WORD-1:0] w_sel_addr, w_sel_wdata;
  // Search order starts one past the previous winner.
  assign w_o0        = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
  assign w_o1        = (w_o0 == 2'd2) ? 2'd0 : w_o0 + 2'd1;
  assign w_o2        = (w_o1 == 2'd2) ? 2'd0 : w_o1 + 2'd1;
  assign w_win       = req[w_o0] ? w_o0 : req[w_o1] ? w_o1 : w_o2;
  assign w_we        = (w_win == 2'd1 && we[1]) || (w_win == 2'd2 && we[2]);
  assign w_sel_addr  = (w_win == 2'd0) ? addr0 : (w_win == 2'd1) ? addr1 : addr2;
  assign w_sel_wdata = (w_win == 2'd1) ? wdata1 : (w_win == 2'd2) ? wdata2 : r_wdata;
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_last  = r_last;
    w_ack   = '0;
    w_gnt   = r_gnt;
    w_rdata = r_rdata;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_rd    = r_rd;
    w_wr    = r_wr;
    case (r_state)
      IDLE: if (|req) begin
        w_state = BUSY;
        w_cnt   = 4'(LATENCY - 1);
        w_last  = w_win;
        w_gnt   = 3'b001 << w_win;
        w_addr  = w_sel_addr;
        w_wdata = w_sel_wdata;
        w_rd    = !w_we;
        w_wr    = w_we;
      end
      BUSY: if (r_cnt == 4'd0) begin
        w_state = ACK;
        w_ack   = r_gnt;
        w_rd    = 1'b0;
        w_wr    = 1'b0;
        w_rdata = r_rd ? mem_rdata : r_rdata;
      end else w_cnt = r_cnt - 4'd1;
      ACK: begin
        w_state = IDLE;
        w_gnt   = '0;
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= 2'd2;
      r_ack   <= '0;
      r_gnt   <= '0;
      r_rdata <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_last  <= w_last;
      r_ack   <= w_ack;
      r_gnt   <= w_gnt;
      r_rdata <= w_rdata;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_rd    <= w_rd;
      r_wr    <= w_wr;
    end
  end
  assign ack        = r_ack;
  assign gnt        = r_gnt;
  assign rdata      = r_rdata;
  assign mem_readM  = r_rd;
  assign mem_writeM = r_wr;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed-vector bench for mem_port_arbiter at LATENCY=2.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  req = '0, we = '0;
  logic [15:0] addr0 = '0, addr1 = '0, addr2 = '0, wdata1 = '0, wdata2 = '0;
  logic [15:0] mem_rdata = '0;
  logic [2:0]  ack, gnt;
  logic [15:0] rdata, mem_addr, mem_wdata;
  logic        mem_readM, mem_writeM;
  int          n_tests = 0, n_fail = 0;
  mem_port_arbiter #(.WORD(16), .LATENCY(2)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .wdata1(wdata1), .wdata2(wdata2),
    .ack(ack), .gnt(gnt), .rdata(rdata),
    .mem_readM(mem_readM), .mem_writeM(mem_writeM),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  initial begin
    tick();
    tick();
    chk("rst_ctl", {29'd0, ack, gnt, mem_readM, mem_writeM}, 32'd0);
    chk("rst_rdata", {16'd0, rdata}, 32'd0);
    chk("rst_addr", {mem_addr, mem_wdata}, 32'd0);
    reset_n = 1'b1;
    // single fetch
    req = 3'b001; addr0 = 16'h0010; mem_rdata = 16'hA5A5;
    tick();
    chk("f_busy1", {27'd0, gnt, mem_readM, mem_writeM}, {27'd0, 3'b001, 2'b10});
    chk("f_addr", {16'd0, mem_addr}, 32'h0010);
    chk("f_noack1", {29'd0, ack}, 32'd0);
    tick();
    chk("f_busy2", {27'd0, ack, mem_readM, mem_writeM}, {27'd0, 3'b000, 2'b10});
    tick();
    chk("f_ack", {27'd0, ack, mem_readM, mem_writeM}, {27'd0, 3'b001, 2'b00});
    chk("f_rdata", {16'd0, rdata}, 32'hA5A5);
    req = 3'b000;
    tick();
    chk("f_idle", {29'd0, ack, gnt}, 32'd0);
    // fetch with we set stays a read
    req = 3'b001; we = 3'b001; addr0 = 16'h0020;
    tick();
    chk("fw_strobe", {30'd0, mem_readM, mem_writeM}, 32'b10);
    tick();
    chk("fw_strobe2", {30'd0, mem_readM, mem_writeM}, 32'b10);
    tick();
    chk("fw_ack", {29'd0, ack}, 32'b001);
    req = 3'b000; we = 3'b000;
    tick();
    // DMA write
    req = 3'b100; we = 3'b100; addr2 = 16'h0200; wdata2 = 16'h1234; mem_rdata = 16'hFFFF;
    tick();
    chk("d_busy1", {27'd0, gnt, mem_readM, mem_writeM}, {27'd0, 3'b100, 2'b01});
    chk("d_cmd", {mem_addr, mem_wdata}, 32'h0200_1234);
    tick();
    chk("d_busy2", {30'd0, mem_readM, mem_writeM}, 32'b01);
    tick();
    chk("d_ack", {27'd0, ack, mem_readM, mem_writeM}, {27'd0, 3'b100, 2'b00});
    chk("d_rdata_kept", {16'd0, rdata}, 32'hA5A5);
    req = 3'b000; we = 3'b000;
    tick();
    // fairness from reset
    reset_n = 1'b0;
    tick();
    chk("fair_rst", {29'd0, gnt}, 32'd0);
    reset_n = 1'b1; req = 3'b111;
    addr0 = 16'h0100; addr1 = 16'h0110; addr2 = 16'h0120;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("fair_gnt%0d", k), {29'd0, gnt}, 32'(3'b001 << (k % 3)));
      chk($sformatf("fair_addr%0d", k), {16'd0, mem_addr}, 32'h0100 + 32'(16 * (k % 3)));
      mem_rdata = 16'hC000 + 16'(k);
      tick();
      tick();
      chk($sformatf("fair_ack%0d", k), {29'd0, ack}, 32'(3'b001 << (k % 3)));
      chk($sformatf("fair_rdata%0d", k), {16'd0, rdata}, 32'hC000 + 32'(k));
      tick();
      chk($sformatf("fair_idle%0d", k), {29'd0, ack, gnt}, 32'd0);
      if (k == 5) req = 3'b010;
    end
    // late arrival of fetch while data is in flight
    tick();
    chk("late_gnt1", {29'd0, gnt}, 32'b010);
    req = 3'b011;
    tick();
    tick();
    chk("late_ack1", {29'd0, ack}, 32'b010);
    tick();
    tick();
    chk("late_gnt0", {29'd0, gnt}, 32'b001);
    req = 3'b000;
    tick();
    tick();
    chk("late_ack0", {29'd0, ack}, 32'b001);
    tick();
    // reset during the first BUSY cycle
    req = 3'b010;
    tick();
    chk("rb_busy", {27'd0, gnt, mem_readM, mem_writeM}, {27'd0, 3'b010, 2'b10});
    reset_n = 1'b0;
    tick();
    chk("rb_cleared", {27'd0, ack, gnt, mem_readM, mem_writeM}, 32'd0);
    reset_n = 1'b1; req = 3'b111;
    tick();
    chk("rb_regrant", {29'd0, gnt}, 32'b001);
    tick();
    chk("rb_noack", {29'd0, ack}, 32'd0);
    req = 3'b000;
    tick();
    chk("rb_ack0", {29'd0, ack}, 32'b001);
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
